// File: rtl/space_invaders_pkg.sv
// Shared types and constants for the Space Invaders video datapath.
// Holds the screen geometry, the coordinate type used by every mover and
// the colour mapper, the bullet FSM state type, and the default player row
// and bullet length. The mapper draws the bullet with the same length, so
// both sides take it from here.
package space_invaders_pkg;

    typedef logic [9:0] coord_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int DEFAULT_PLAYER_Y   = 440;
    localparam int DEFAULT_BULLET_LEN = 4;

    typedef enum logic [1:0] {
        IDLE,
        FLIGHT,
        COOLDOWN
    } bullet_state_t;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings an asynchronous frame-rate level (VGA vsync) into the clk_i domain.
// It uses two synchroniser flops and then emits a one-cycle pulse on each
// rising edge. The pulse appears two to three clk_i cycles after the level
// rises. The player, enemy and bullet movers all share this block.
// Ports:
//   clk_i   - system clock
//   rst_ni  - synchronous active-low reset, clears all three flops
//   level_i - asynchronous frame strobe level
//   tick_o  - one-cycle pulse per rising edge of level_i
module frame_tick_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic tick_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= level_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign tick_o = sync_q & ~prev_q;

endmodule

// File: rtl/bullet_controller.sv
// Owns the single player bullet: spawn on fire, one upward step per frame,
// despawn at screen top or on hit, then a cooldown before the next shot.
// Drives the colour mapper's bullet_in / bulletX / bulletY inputs.
// Optional feature (macro BULLET_AUTOFIRE_EN): while IDLE, a held fire level
// also spawns. By default only a fire rising edge spawns.
// Ports:
//   Clk       - system clock
//   Reset     - synchronous active-low reset
//   frame_clk - asynchronous vsync-rate strobe
//   fire      - fire key level (Clk domain)
//   playerX   - player sprite left column
//   hit       - collision pulse, kills an in-flight bullet
//   bullet_in - bullet visible
//   bulletX   - bullet column
//   bulletY   - bullet top row
//   fire_ack  - one-cycle pulse on spawn
module bullet_controller
    import space_invaders_pkg::*;
#(
    parameter int PLAYER_Y        = DEFAULT_PLAYER_Y,
    parameter int PLAYER_X_OFS    = 8,
    parameter int BULLET_LEN      = DEFAULT_BULLET_LEN,
    parameter int BULLET_STEP     = 6,
    parameter int COOLDOWN_FRAMES = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [9:0] playerX,
    input  logic       hit,
    output logic       bullet_in,
    output logic [9:0] bulletX,
    output logic [9:0] bulletY,
    output logic       fire_ack
);

    localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam coord_t SPAWN_Y = coord_t'(PLAYER_Y - BULLET_LEN);
    localparam coord_t STEP_Y  = coord_t'(BULLET_STEP);
    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_FRAMES);
    // With no cooldown, a dead bullet re-arms immediately.
    localparam bullet_state_t KILL_STATE = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;

    bullet_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bullet_in_q, bullet_in_d;
    coord_t           bx_q, bx_d;
    coord_t           by_q, by_d;
    logic             fire_ack_q, fire_ack_d;
    logic             fire_prev_q;

    logic frame_tick;
    logic fire_evt;
    logic trig;

    frame_tick_sync u_tick (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .level_i(frame_clk),
        .tick_o (frame_tick)
    );

    assign fire_evt = fire & ~fire_prev_q;

`ifdef BULLET_AUTOFIRE_EN
    assign trig = fire_evt | fire;
`else
    assign trig = fire_evt;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bullet_in_d = bullet_in_q;
        bx_d        = bx_q;
        by_d        = by_q;
        fire_ack_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A same-cycle frame tick is ignored; the new bullet starts at SPAWN_Y.
                if (trig) begin
                    state_d     = FLIGHT;
                    bullet_in_d = 1'b1;
                    bx_d        = coord_t'(playerX + PLAYER_X_OFS);
                    by_d        = SPAWN_Y;
                    fire_ack_d  = 1'b1;
                end
            end
            FLIGHT: begin
                // Hit wins over a tick. Reaching the top despawns instead of wrapping.
                if (hit || (frame_tick && (by_q < STEP_Y))) begin
                    bullet_in_d = 1'b0;
                    state_d     = KILL_STATE;
                    cnt_d       = CD_LOAD;
                end else if (frame_tick) begin
                    by_d = by_q - STEP_Y;
                end
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bullet_in_q <= 1'b0;
            bx_q        <= '0;
            by_q        <= '0;
            fire_ack_q  <= 1'b0;
            fire_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bullet_in_q <= bullet_in_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            fire_ack_q  <= fire_ack_d;
            fire_prev_q <= fire;
        end
    end

    assign bullet_in = bullet_in_q;
    assign bulletX   = bx_q;
    assign bulletY   = by_q;
    assign fire_ack  = fire_ack_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Self-checking bench for bullet_controller with the default parameters
// (spawn row 436, X offset 8, step 6, cooldown 10 ticks).
module tb_bullet_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic       fire = 1'b0;
    logic [9:0] playerX = '0;
    logic       hit = 1'b0;
    logic       bullet_in;
    logic [9:0] bulletX;
    logic [9:0] bulletY;
    logic       fire_ack;

    always #5 Clk = ~Clk;

    bullet_controller dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .frame_clk(frame_clk),
        .fire     (fire),
        .playerX  (playerX),
        .hit      (hit),
        .bullet_in(bullet_in),
        .bulletX  (bulletX),
        .bulletY  (bulletY),
        .fire_ack (fire_ack)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive values for the next clock edge.
    logic d_rst  = 1'b0;
    logic d_fc   = 1'b0;
    logic d_fire = 1'b0;
    logic d_hit  = 1'b0;
    int   d_px   = 0;

    // Reference model. It tracks whether a bullet is alive, its coordinates,
    // and how many frame ticks of cooldown remain. The frame strobe is kept
    // as the history of levels seen at recent edges.
    bit m_active = 0;
    int m_x = 0;
    int m_y = 0;
    bit m_ack = 0;
    int m_cool = 0;
    bit m_fprev = 0;
    bit m_hist[3] = '{0, 0, 0};

    task automatic model_edge(input bit r, input bit fc, input bit f, input bit h, input int px);
        bit tick;
        bit trig;
        if (!r) begin
            m_active = 0; m_x = 0; m_y = 0; m_ack = 0; m_cool = 0; m_fprev = 0;
            m_hist = '{0, 0, 0};
            return;
        end
        // The strobe level seen two edges back rose relative to the one three edges back.
        tick = m_hist[1] && !m_hist[2];
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = fc;
`ifdef BULLET_AUTOFIRE_EN
        trig = f;
`else
        trig = f && !m_fprev;
`endif
        m_fprev = f;
        m_ack = 0;
        if (m_active) begin
            if (h || (tick && m_y < 6)) begin
                m_active = 0;
                m_cool = 10;
            end else if (tick) begin
                m_y = m_y - 6;
            end
        end else if (m_cool > 0) begin
            if (tick) m_cool--;
        end else if (trig) begin
            m_active = 1;
            m_x = (px + 8) % 1024;
            m_y = 436;
            m_ack = 1;
        end
    endtask

    task automatic step();
        Reset = d_rst; frame_clk = d_fc; fire = d_fire; hit = d_hit; playerX = 10'(d_px);
        @(posedge Clk);
        model_edge(d_rst, d_fc, d_fire, d_hit, d_px);
        #1;
        chk("bullet_in", int'(bullet_in), int'(m_active));
        chk("bulletX", int'(bulletX), m_x);
        chk("bulletY", int'(bulletY), m_y);
        chk("fire_ack", int'(fire_ack), int'(m_ack));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One frame strobe pulse; the resulting tick lands on the third edge.
    task automatic ftick();
        d_fc = 1'b1; steps(3);
        d_fc = 1'b0; steps(3);
    endtask

    task automatic fticks(input int n);
        for (int i = 0; i < n; i++) ftick();
    endtask

    task automatic pulse_fire();
        d_fire = 1'b1; step();
        d_fire = 1'b0; step();
    endtask

    initial begin
        int hold;
        // Reset state
        d_rst = 1'b0; steps(2);
        chk("rst_bullet_in", int'(bullet_in), 0);
        chk("rst_bulletX", int'(bulletX), 0);
        chk("rst_bulletY", int'(bulletY), 0);
        chk("rst_fire_ack", int'(fire_ack), 0);
        d_rst = 1'b1; steps(2);

        // Basic spawn
        d_px = 100; d_fire = 1'b1; step();
        chk("spawn_in", int'(bullet_in), 1);
        chk("spawn_x", int'(bulletX), 108);
        chk("spawn_y", int'(bulletY), 436);
        chk("spawn_ack", int'(fire_ack), 1);
        d_fire = 1'b0; step();
        chk("spawn_ack_drop", int'(fire_ack), 0);
        fticks(3);
        chk("three_ticks_y", int'(bulletY), 418);

        // Top of screen
        fticks(69);
        chk("top_y4", int'(bulletY), 4);
        chk("top_alive", int'(bullet_in), 1);
        ftick();
        chk("top_despawn_in", int'(bullet_in), 0);
        chk("top_hold_y", int'(bulletY), 4);
        for (int i = 0; i < 10; i++) begin
            pulse_fire();
            chk("cool_no_spawn", int'(bullet_in), 0);
            ftick();
        end
        pulse_fire();
        chk("rearm_spawn", int'(bullet_in), 1);

        // Hit priority over a same-cycle tick
        fticks(6);
        chk("pre_hit_y", int'(bulletY), 400);
        d_fc = 1'b1; steps(2);
        d_hit = 1'b1; step();
        d_hit = 1'b0; d_fc = 1'b0; steps(3);
        chk("hit_in", int'(bullet_in), 0);
        chk("hit_y", int'(bulletY), 400);
        pulse_fire();
        chk("hit_cooldown", int'(bullet_in), 0);
        fticks(10);

        // Fire during flight
        d_px = 50; pulse_fire();
        chk("flight_x", int'(bulletX), 58);
        fticks(23);
        chk("flight_y", int'(bulletY), 298);
        pulse_fire();
        d_px = 200; step();
        ftick();
        chk("flight_x_frozen", int'(bulletX), 58);
        chk("flight_y_next", int'(bulletY), 292);
        d_hit = 1'b1; step(); d_hit = 1'b0;
        fticks(10);

        // Held fire across despawn and cooldown
        d_fire = 1'b1; step();
        chk("held_spawn", int'(bullet_in), 1);
        d_hit = 1'b1; step(); d_hit = 1'b0;
        fticks(10);
        steps(2);
`ifdef BULLET_AUTOFIRE_EN
        chk("held_autofire", int'(bullet_in), 1);
        d_hit = 1'b1; step(); d_hit = 1'b0;
        d_fire = 1'b0; step();
        fticks(10);
`else
        chk("held_no_refire", int'(bullet_in), 0);
        d_fire = 1'b0; step();
        d_fire = 1'b1; step();
        chk("repress_spawn", int'(bullet_in), 1);
        d_fire = 1'b0;
        d_hit = 1'b1; step(); d_hit = 1'b0;
        fticks(10);
`endif

        // Mid-flight reset, then a reset glitch between edges
        d_px = 0; pulse_fire();
        fticks(31);
        chk("pre_rst_y", int'(bulletY), 250);
        d_rst = 1'b0; step(); d_rst = 1'b1;
        chk("mid_rst_in", int'(bullet_in), 0);
        chk("mid_rst_x", int'(bulletX), 0);
        chk("mid_rst_y", int'(bulletY), 0);
        steps(2);
        pulse_fire();
        Reset = 1'b0; #2; Reset = 1'b1;
        step();
        chk("glitch_in", int'(bullet_in), 1);
        chk("glitch_y", int'(bulletY), 436);

        // Randomised traffic against the model
        hold = 3;
        for (int i = 0; i < 4000; i++) begin
            d_rst = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 5) == 0) d_fire = ~d_fire;
            d_hit = ($urandom_range(0, 79) == 0);
            d_px  = int'($urandom_range(0, 1023));
            if (hold == 0) begin
                d_fc = ~d_fc;
                hold = int'($urandom_range(1, 5));
            end else begin
                hold--;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
